// File: rtl/sga_pkg.sv
// Shared definitions for the pixel write path.
// Raster defaults, payload widths and the framebuffer word layout.
package sga_pkg;

   localparam int H_RES_D = 160;
   localparam int V_RES_D = 120;
   localparam int AW_D    = 15;
   localparam int CW_D    = 8;
   localparam int DEPTH_D = 8;

   typedef struct packed {
      logic [AW_D-1:0] addr;
      logic [CW_D-1:0] colour;
   } fb_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO, head visible combinationally on rdata.
// Ports: clk/rst, push/wdata, pop/rdata, level, full, empty.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   localparam int PW   = $clog2(DEPTH),
   localparam int LW   = PW + 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);

   // A full FIFO still takes a push when the head leaves the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Empty head reads as zero so the port is clean out of reset.
   assign rdata = empty ? '0 : mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + PW'(1);
         end
         if (do_pop) begin
            rptr <= rptr + PW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/pixel_fb_writer.sv
// Clips shifted pixels, linearises (x,y) and queues framebuffer writes.
// Ports: XIN/YIN/COLOR/VALID in, MEM_* write port, CLIPPED, OVERFLOW, LEVEL.
module pixel_fb_writer
   import sga_pkg::*;
#(
   parameter int H_RES = H_RES_D,
   parameter int V_RES = V_RES_D,
   parameter int AW    = AW_D,
   parameter int CW    = CW_D,
   parameter int DEPTH = DEPTH_D
)(
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic [7:0]             XIN,
   input  logic [7:0]             YIN,
   input  logic [CW-1:0]          COLOR,
   input  logic                   VALID,
   output logic [AW-1:0]          MEM_ADDR,
   output logic [CW-1:0]          MEM_DATA,
   output logic                   MEM_WE,
   input  logic                   MEM_READY,
   output logic                   CLIPPED,
   output logic                   OVERFLOW,
   input  logic                   CLR_OVF,
   output logic [$clog2(DEPTH):0] LEVEL
);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [CW-1:0] colour;
   } slot_t;

   localparam logic [15:0] HMAX = 16'(H_RES);
   localparam logic [15:0] VMAX = 16'(V_RES);

   logic          in_range;
   logic [AW:0]   addr_full;
   logic          s1_valid;
   logic [AW-1:0] s1_addr;
   logic [CW-1:0] s1_col;
   logic          pop;
   logic          full;
   logic          empty;
   logic          drop;
   slot_t         wword;
   slot_t         head;

   assign in_range = ({8'd0, XIN} < HMAX) && ({8'd0, YIN} < VMAX);

   // One spare bit keeps the product exact before truncation.
   assign addr_full = (AW+1)'(YIN) * (AW+1)'(H_RES) + (AW+1)'(XIN);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s1_col   <= '0;
         CLIPPED  <= 1'b0;
      end else begin
         s1_valid <= VALID & in_range;
         CLIPPED  <= VALID & ~in_range;
         if (VALID) begin
            s1_addr <= addr_full[AW-1:0];
            s1_col  <= COLOR;
         end
      end
   end

   assign wword.addr   = s1_addr;
   assign wword.colour = s1_col;

   assign MEM_WE = ~empty;
   assign pop    = MEM_WE & MEM_READY;
   assign drop   = s1_valid & full & ~pop;

   sync_fifo #(
      .W     ($bits(slot_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (ACLK),
      .rst   (ARESET),
      .push  (s1_valid),
      .wdata (wword),
      .pop   (pop),
      .rdata (head),
      .level (LEVEL),
      .full  (full),
      .empty (empty)
   );

   assign MEM_ADDR = head.addr;
   assign MEM_DATA = head.colour;

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         OVERFLOW <= 1'b0;
      end else if (drop) begin
         OVERFLOW <= 1'b1;
      end else if (CLR_OVF) begin
         OVERFLOW <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Self-checking bench for pixel_fb_writer.
// Queue-based reference model of the clip/queue/drain behaviour.
module tb_pixel_fb_writer;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [7:0]  XIN = '0;
   logic [7:0]  YIN = '0;
   logic [7:0]  COLOR = '0;
   logic        VALID = 1'b0;
   logic [14:0] MEM_ADDR;
   logic [7:0]  MEM_DATA;
   logic        MEM_WE;
   logic        MEM_READY = 1'b0;
   logic        CLIPPED;
   logic        OVERFLOW;
   logic        CLR_OVF = 1'b0;
   logic [3:0]  LEVEL;

   int n_run = 0;
   int n_fail = 0;

   int  mq[$];
   int  exp_log[$];
   int  wr_log[$];
   bit  m_clip;
   bit  m_ovf;
   bit  m_s1v;
   int  m_s1w;

   pixel_fb_writer dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .XIN       (XIN),
      .YIN       (YIN),
      .COLOR     (COLOR),
      .VALID     (VALID),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_DATA  (MEM_DATA),
      .MEM_WE    (MEM_WE),
      .MEM_READY (MEM_READY),
      .CLIPPED   (CLIPPED),
      .OVERFLOW  (OVERFLOW),
      .CLR_OVF   (CLR_OVF),
      .LEVEL     (LEVEL)
   );

   always #5 ACLK = ~ACLK;

   function automatic void model_reset();
      mq.delete();
      m_clip = 0;
      m_ovf  = 0;
      m_s1v  = 0;
      m_s1w  = 0;
   endfunction

   // Apply one cycle of inputs, log any real write, advance the model.
   task automatic drive(input bit v, input int x, input int y,
                        input int c, input bit rdy, input bit clr);
      int sz;
      bit p;
      bit inr;
      VALID     = v;
      XIN       = 8'(x);
      YIN       = 8'(y);
      COLOR     = 8'(c);
      MEM_READY = rdy;
      CLR_OVF   = clr;
      if (MEM_WE === 1'b1 && rdy)
         wr_log.push_back(int'({MEM_ADDR, MEM_DATA}));
      sz = mq.size();
      p  = (sz != 0) && rdy;
      if (p) begin
         exp_log.push_back(mq[0]);
         void'(mq.pop_front());
      end
      if (m_s1v) begin
         if (sz < 8 || p) mq.push_back(m_s1w);
         else m_ovf = 1;
      end else if (clr) begin
         m_ovf = 0;
      end
      if (m_s1v && !(sz < 8 || p)) m_ovf = 1;
      else if (clr) m_ovf = 0;
      inr    = (x < 160) && (y < 120);
      m_s1v  = v && inr;
      m_clip = v && !inr;
      m_s1w  = ((y * 160 + x) << 8) | (c & 255);
      @(posedge ACLK);
      #1;
   endtask

   task automatic idle(input bit rdy);
      drive(0, 0, 0, 0, rdy, 0);
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      n_run++;
      if (MEM_WE !== 1'b0) begin
         n_fail++; $display("FAIL reset_we got %0b want 0", MEM_WE);
      end
      n_run++;
      if (MEM_ADDR !== 15'd0) begin
         n_fail++; $display("FAIL reset_addr got %0d want 0", MEM_ADDR);
      end
      n_run++;
      if (MEM_DATA !== 8'd0) begin
         n_fail++; $display("FAIL reset_data got %0h want 0", MEM_DATA);
      end
      n_run++;
      if (CLIPPED !== 1'b0 || OVERFLOW !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags got clip=%0b ovf=%0b want 0 0",
                  CLIPPED, OVERFLOW);
      end
      n_run++;
      if (LEVEL !== 4'd0) begin
         n_fail++; $display("FAIL reset_level got %0d want 0", LEVEL);
      end
      ARESET = 1'b0;
      model_reset();
   endtask

   task automatic test_single();
      drive(1, 10, 2, 8'h5A, 1, 0);
      n_run++;
      if (MEM_WE !== 1'b0) begin
         n_fail++; $display("FAIL single_early_we got %0b want 0", MEM_WE);
      end
      idle(1);
      n_run++;
      if (MEM_WE !== 1'b1 || MEM_ADDR !== 15'd330 || MEM_DATA !== 8'h5A) begin
         n_fail++;
         $display("FAIL single_write got we=%0b a=%0d d=%0h want 1 330 5a",
                  MEM_WE, MEM_ADDR, MEM_DATA);
      end
      idle(1);
      n_run++;
      if (MEM_WE !== 1'b0 || LEVEL !== 4'd0) begin
         n_fail++;
         $display("FAIL single_done got we=%0b lvl=%0d want 0 0",
                  MEM_WE, LEVEL);
      end
   endtask

   task automatic test_boundary();
      drive(1, 159, 119, 8'hC3, 1, 0);
      idle(1);
      n_run++;
      if (MEM_WE !== 1'b1 || MEM_ADDR !== 15'd19199) begin
         n_fail++;
         $display("FAIL corner_addr got we=%0b a=%0d want 1 19199",
                  MEM_WE, MEM_ADDR);
      end
      drive(1, 160, 0, 8'h11, 1, 0);
      n_run++;
      if (CLIPPED !== 1'b1 || MEM_WE !== 1'b0) begin
         n_fail++;
         $display("FAIL clip_x got clip=%0b we=%0b want 1 0",
                  CLIPPED, MEM_WE);
      end
      drive(1, 0, 120, 8'h22, 1, 0);
      n_run++;
      if (CLIPPED !== 1'b1 || MEM_WE !== 1'b0) begin
         n_fail++;
         $display("FAIL clip_y got clip=%0b we=%0b want 1 0",
                  CLIPPED, MEM_WE);
      end
      idle(1);
      n_run++;
      if (CLIPPED !== 1'b0 || MEM_WE !== 1'b0 || LEVEL !== 4'd0) begin
         n_fail++;
         $display("FAIL clip_after got clip=%0b we=%0b lvl=%0d want 0 0 0",
                  CLIPPED, MEM_WE, LEVEL);
      end
   endtask

   task automatic test_overflow();
      wr_log.delete();
      exp_log.delete();
      for (int x = 0; x < 9; x++)
         drive(1, x, 0, $urandom_range(0, 255), 0, 0);
      idle(0);
      n_run++;
      if (MEM_ADDR !== 15'd0 || MEM_WE !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_hold1 got a=%0d we=%0b want 0 1",
                  MEM_ADDR, MEM_WE);
      end
      idle(0);
      n_run++;
      if (LEVEL !== 4'd8) begin
         n_fail++; $display("FAIL ovf_level got %0d want 8", LEVEL);
      end
      n_run++;
      if (OVERFLOW !== 1'b1) begin
         n_fail++; $display("FAIL ovf_flag got %0b want 1", OVERFLOW);
      end
      n_run++;
      if (MEM_ADDR !== 15'd0 || MEM_DATA !== 8'(mq[0])) begin
         n_fail++;
         $display("FAIL stall_hold2 got a=%0d d=%0h want 0 %0h",
                  MEM_ADDR, MEM_DATA, mq[0] & 255);
      end
   endtask

   task automatic test_full_pop();
      int want[9];
      want = '{0, 1, 2, 3, 4, 5, 6, 7, 20};
      drive(1, 20, 0, 8'h77, 0, 0);
      idle(1);
      n_run++;
      if (LEVEL !== 4'd8 || OVERFLOW !== 1'b1) begin
         n_fail++;
         $display("FAIL full_pop got lvl=%0d ovf=%0b want 8 1",
                  LEVEL, OVERFLOW);
      end
      n_run++;
      if (MEM_ADDR !== 15'd1) begin
         n_fail++; $display("FAIL full_pop_head got %0d want 1", MEM_ADDR);
      end
      repeat (10) idle(1);
      n_run++;
      if (LEVEL !== 4'd0 || wr_log.size() != 9) begin
         n_fail++;
         $display("FAIL drain_count got lvl=%0d n=%0d want 0 9",
                  LEVEL, wr_log.size());
      end
      for (int i = 0; i < 9 && i < wr_log.size(); i++) begin
         n_run++;
         if ((wr_log[i] >> 8) != want[i] || wr_log[i] != exp_log[i]) begin
            n_fail++;
            $display("FAIL drain_order[%0d] got %0h want addr %0d word %0h",
                     i, wr_log[i], want[i], exp_log[i]);
         end
      end
   endtask

   task automatic test_clr_ovf();
      drive(0, 0, 0, 0, 1, 1);
      CLR_OVF = 1'b0;
      n_run++;
      if (OVERFLOW !== 1'b0) begin
         n_fail++; $display("FAIL clr_ovf got %0b want 0", OVERFLOW);
      end
   endtask

   task automatic test_toggle();
      wr_log.delete();
      exp_log.delete();
      for (int i = 0; i < 20; i++) begin
         drive(1, $urandom_range(0, 175), $urandom_range(0, 130),
               $urandom_range(0, 255), i[0], 0);
         n_run++;
         if (LEVEL > 4'd8 || int'(LEVEL) != mq.size()) begin
            n_fail++;
            $display("FAIL toggle_level[%0d] got %0d want %0d",
                     i, LEVEL, mq.size());
         end
      end
      repeat (12) idle(1);
      n_run++;
      if (wr_log.size() != exp_log.size() || OVERFLOW !== m_ovf) begin
         n_fail++;
         $display("FAIL toggle_count got n=%0d ovf=%0b want n=%0d ovf=%0b",
                  wr_log.size(), OVERFLOW, exp_log.size(), m_ovf);
      end
      for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
         n_run++;
         if (wr_log[i] != exp_log[i]) begin
            n_fail++;
            $display("FAIL toggle_word[%0d] got %0h want %0h",
                     i, wr_log[i], exp_log[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int x = 2; x < 7; x++)
         drive(1, x, 3, x * 7, 0, 0);
      idle(0);
      idle(0);
      n_run++;
      if (LEVEL !== 4'd5 || MEM_WE !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset got lvl=%0d we=%0b want 5 1",
                  LEVEL, MEM_WE);
      end
      ARESET = 1'b1;
      #1;
      n_run++;
      if (LEVEL !== 4'd0 || MEM_WE !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got lvl=%0d we=%0b want 0 0",
                  LEVEL, MEM_WE);
      end
      model_reset();
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      wr_log.delete();
      exp_log.delete();
      drive(1, 1, 1, 8'h3C, 1, 0);
      idle(1);
      n_run++;
      if (MEM_WE !== 1'b1 || MEM_ADDR !== 15'd161 || MEM_DATA !== 8'h3C) begin
         n_fail++;
         $display("FAIL post_reset got we=%0b a=%0d d=%0h want 1 161 3c",
                  MEM_WE, MEM_ADDR, MEM_DATA);
      end
      repeat (3) idle(1);
      n_run++;
      if (wr_log.size() != 1 || (wr_log.size() == 1 && (wr_log[0] >> 8) != 161)) begin
         n_fail++;
         $display("FAIL no_stale got n=%0d want 1 write to 161",
                  wr_log.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundary();
      test_overflow();
      test_full_pop();
      test_clr_ovf();
      test_toggle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
